// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single 16-bit memory port between the two-beat fetch
//               path and the single-beat data path. Fair alternation on
//               contention. Define MEM_WAIT_EN to honour mem_ready.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    input  logic        f_abort,
    output logic [15:0] f_opc,
    output logic [15:0] f_arg,
    output logic        f_hold,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_F_OPC = 2'd1,
        S_F_ARG = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t      state_q;
    logic        last_data_q;
    logic        abort_q;
    logic [15:0] opc_stage_q;
    logic [15:0] f_opc_q;
    logic [15:0] f_arg_q;
    logic        f_hold_q;
    logic [15:0] d_rdata_q;
    logic        d_ack_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;

    logic ready;
`ifdef MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready            = 1'b1;
`endif

    // A requester that is completing this cycle is masked so the other side
    // gets the free grant slot.
    logic eff_data;
    logic eff_fetch;
    logic grant_data;
    logic grant_fetch;
    logic abort_now;

    assign eff_data    = d_req & ~d_ack_q;
    assign eff_fetch   = f_req & f_hold_q;
    assign grant_data  = eff_data & (~eff_fetch | ~last_data_q);
    assign grant_fetch = eff_fetch & ~grant_data;
    assign abort_now   = abort_q | f_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_data_q <= 1'b0;
            abort_q     <= 1'b0;
            opc_stage_q <= 16'h0000;
            f_opc_q     <= 16'h0000;
            f_arg_q     <= 16'h0000;
            f_hold_q    <= 1'b1;
            d_rdata_q   <= 16'h0000;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
        end else begin
            f_hold_q <= 1'b1;
            d_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_data) begin
                        state_q     <= S_DATA;
                        last_data_q <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                    end else if (grant_fetch) begin
                        state_q     <= S_F_OPC;
                        last_data_q <= 1'b0;
                        abort_q     <= 1'b0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= f_addr;
                    end
                end
                S_F_OPC: begin
                    if (f_abort) begin
                        abort_q <= 1'b1;
                    end
                    if (ready) begin
                        if (abort_now) begin
                            state_q  <= S_IDLE;
                            abort_q  <= 1'b0;
                            mem_en_q <= 1'b0;
                        end else begin
                            state_q     <= S_F_ARG;
                            opc_stage_q <= mem_rdata;
                            mem_addr_q  <= mem_addr_q + 16'd2;
                        end
                    end
                end
                S_F_ARG: begin
                    if (f_abort) begin
                        abort_q <= 1'b1;
                    end
                    if (ready) begin
                        state_q  <= S_IDLE;
                        abort_q  <= 1'b0;
                        mem_en_q <= 1'b0;
                        // Opcode is staged so an aborted fetch leaves both
                        // visible words untouched.
                        if (!abort_now) begin
                            f_opc_q  <= opc_stage_q;
                            f_arg_q  <= mem_rdata;
                            f_hold_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (ready) begin
                        state_q  <= S_IDLE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        d_ack_q  <= 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign f_opc     = f_opc_q;
    assign f_arg     = f_arg_q;
    assign f_hold    = f_hold_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_abort;
    logic [15:0] f_opc;
    logic [15:0] f_arg;
    logic        f_hold;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    logic [15:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_abort   (f_abort),
        .f_opc     (f_opc),
        .f_arg     (f_arg),
        .f_hold    (f_hold),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (f_hold !== 1'b1) begin errors++; $display("FAIL reset_f_hold: got %b expected 1", f_hold); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack: got %b expected 0", d_ack); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
        checks++; if ({f_opc, f_arg, d_rdata} !== 48'h0) begin errors++; $display("FAIL reset_data_regs: got %h %h %h expected zeros", f_opc, f_arg, d_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_contention();
        mem[16'h2000] = 16'h5555;
        mem[16'h0200] = 16'h1111;
        mem[16'h0202] = 16'h2222;
        mem[16'h0300] = 16'h3333;
        mem[16'h0302] = 16'h4444;
        f_req = 1'b1; f_addr = 16'h0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2000;
        tick();  // N+1
        checks++; if (mem_addr !== 16'h2000 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL contention_data_first: got en=%b we=%b addr=%h expected en=1 we=0 addr=2000", mem_en, mem_we, mem_addr); end
        tick();  // N+2
        checks++; if (d_ack !== 1'b1 || d_rdata !== 16'h5555) begin errors++; $display("FAIL contention_d_ack: got ack=%b rdata=%h expected ack=1 rdata=5555", d_ack, d_rdata); end
        d_req = 1'b0;
        tick();  // N+3
        checks++; if (mem_addr !== 16'h0200 || mem_en !== 1'b1) begin errors++; $display("FAIL contention_fetch_granted: got en=%b addr=%h expected en=1 addr=0200", mem_en, mem_addr); end
        f_req = 1'b0;
        tick();  // N+4
        tick();  // N+5
        checks++; if (f_hold !== 1'b0 || f_opc !== 16'h1111 || f_arg !== 16'h2222) begin errors++; $display("FAIL contention_fetch_done: got hold=%b opc=%h arg=%h expected hold=0 opc=1111 arg=2222", f_hold, f_opc, f_arg); end
        tick();  // N+6 : fresh conflict, last grant was fetch
        f_req = 1'b1; f_addr = 16'h0300;
        d_req = 1'b1; d_addr = 16'h2000;
        tick();  // N+7
        checks++; if (mem_addr !== 16'h2000) begin errors++; $display("FAIL contention_alt_data: got addr=%h expected 2000", mem_addr); end
        f_req = 1'b0; d_req = 1'b0;
        tick();  // N+8
        checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL contention_alt_ack: got %b expected 1", d_ack); end
        tick();  // N+9 : conflict, last grant was data
        f_req = 1'b1; d_req = 1'b1;
        tick();  // N+10
        checks++; if (mem_addr !== 16'h0300 || mem_we !== 1'b0) begin errors++; $display("FAIL contention_alt_fetch: got addr=%h we=%b expected addr=0300 we=0", mem_addr, mem_we); end
        f_req = 1'b0; d_req = 1'b0;
        tick();  // N+11
        tick();  // N+12
        checks++; if (f_hold !== 1'b0 || f_opc !== 16'h3333 || f_arg !== 16'h4444) begin errors++; $display("FAIL contention_alt_fetch_done: got hold=%b opc=%h arg=%h expected 0 3333 4444", f_hold, f_opc, f_arg); end
        tick();  // N+13 : data was still pending-free, port idle
        checks++; if (mem_en !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL contention_idle: got en=%b ack=%b expected 0 0", mem_en, d_ack); end
    endtask

    task automatic test_fetch();
        mem[16'h0100] = 16'hA9C0;
        mem[16'h0102] = 16'h1234;
        f_req = 1'b1; f_addr = 16'h0100;
        tick();
        checks++; if (mem_addr !== 16'h0100 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_opc_beat: got en=%b we=%b addr=%h expected 1 0 0100", mem_en, mem_we, mem_addr); end
        f_req = 1'b0;
        tick();
        checks++; if (mem_addr !== 16'h0102 || mem_en !== 1'b1) begin errors++; $display("FAIL fetch_arg_beat: got en=%b addr=%h expected 1 0102", mem_en, mem_addr); end
        checks++; if (f_hold !== 1'b1) begin errors++; $display("FAIL fetch_hold_early: got %b expected 1", f_hold); end
        tick();
        checks++; if (f_hold !== 1'b0 || f_opc !== 16'hA9C0 || f_arg !== 16'h1234 || mem_en !== 1'b0) begin errors++; $display("FAIL fetch_done: got hold=%b opc=%h arg=%h en=%b expected 0 a9c0 1234 0", f_hold, f_opc, f_arg, mem_en); end
        tick();
        checks++; if (f_hold !== 1'b1) begin errors++; $display("FAIL fetch_hold_pulse_width: got %b expected 1", f_hold); end
    endtask

    task automatic test_wrap();
        mem[16'hFFFE] = 16'h0F0F;
        mem[16'h0000] = 16'hF0F0;
        f_req = 1'b1; f_addr = 16'hFFFE;
        tick();
        f_req = 1'b0;
        checks++; if (mem_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_first: got %h expected fffe", mem_addr); end
        tick();
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_second: got %h expected 0000", mem_addr); end
        tick();
        checks++; if (f_hold !== 1'b0 || f_opc !== 16'h0F0F || f_arg !== 16'hF0F0) begin errors++; $display("FAIL wrap_done: got hold=%b opc=%h arg=%h expected 0 0f0f f0f0", f_hold, f_opc, f_arg); end
        tick();
    endtask

    task automatic test_abort();
        f_req = 1'b1; f_addr = 16'h0400;
        tick();  // N+1 : F_OPC
        checks++; if (mem_addr !== 16'h0400 || mem_en !== 1'b1) begin errors++; $display("FAIL abort_opc_beat: got en=%b addr=%h expected 1 0400", mem_en, mem_addr); end
        f_req = 1'b0; f_abort = 1'b1;
        tick();  // N+2
        f_abort = 1'b0;
        checks++; if (mem_en !== 1'b0 || f_hold !== 1'b1) begin errors++; $display("FAIL abort_to_idle: got en=%b hold=%b expected 0 1", mem_en, f_hold); end
        checks++; if (f_opc !== 16'h0F0F || f_arg !== 16'hF0F0) begin errors++; $display("FAIL abort_words_kept: got opc=%h arg=%h expected 0f0f f0f0", f_opc, f_arg); end
        tick();  // N+3
        checks++; if (mem_en !== 1'b0 || f_hold !== 1'b1 || f_opc !== 16'h0F0F) begin errors++; $display("FAIL abort_no_pulse: got en=%b hold=%b opc=%h expected 0 1 0f0f", mem_en, f_hold, f_opc); end
    endtask

    task automatic test_store_wait();
        int beats;
        beats = WAIT_EN ? 3 : 1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h3000; d_wdata = 16'hBEEF;
        mem_ready = ~WAIT_EN;
        tick();
        d_req = 1'b0;
        for (int k = 0; k < beats; k++) begin
            checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h3000 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_beat_stable[%0d]: got en=%b we=%b addr=%h wdata=%h expected 1 1 3000 beef", k, mem_en, mem_we, mem_addr, mem_wdata); end
            checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL store_early_ack[%0d]: got %b expected 0", k, d_ack); end
            if (k == beats - 1) mem_ready = 1'b1;
            tick();
        end
        checks++; if (d_ack !== 1'b1 || d_rdata !== 16'h5555 || mem_en !== 1'b0) begin errors++; $display("FAIL store_ack: got ack=%b rdata=%h en=%b expected 1 5555 0", d_ack, d_rdata, mem_en); end
        tick();
        checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL store_ack_width: got %b expected 0", d_ack); end
    endtask

    task automatic test_reset_midbeat();
        f_req = 1'b1; f_addr = 16'h0500;
        tick();
        f_req = 1'b0;
        tick();  // F_ARG
        checks++; if (mem_addr !== 16'h0502) begin errors++; $display("FAIL rstmid_arg_beat: got %h expected 0502", mem_addr); end
        mem_ready = 1'b0; rst = 1'b1;
        tick();
        checks++; if (mem_en !== 1'b0 || f_hold !== 1'b1 || d_ack !== 1'b0 || f_opc !== 16'h0000) begin errors++; $display("FAIL rstmid_abandon: got en=%b hold=%b ack=%b opc=%h expected 0 1 0 0000", mem_en, f_hold, d_ack, f_opc); end
        rst = 1'b0; mem_ready = 1'b1;
        tick();
        checks++; if (mem_en !== 1'b0 || f_hold !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL rstmid_after: got en=%b hold=%b ack=%b expected 0 1 0", mem_en, f_hold, d_ack); end
    endtask

    // Transaction-level reference: one outstanding transaction (fetch of two
    // words or a single data access) plus the completion pulse of last cycle.
    task automatic test_random(input int n);
        bit          busy = 1'b0, is_fetch = 1'b0, second = 1'b0, t_we = 1'b0, t_abort = 1'b0;
        bit          last_d = 1'b0, fetch_done = 1'b0, data_done = 1'b0, ready;
        bit          nf, nd, want_d, want_f, pick_d;
        logic [15:0] t_addr = 16'h0, t_wdata = 16'h0, pend = 16'h0, exp_addr;
        logic [15:0] e_opc = 16'h0, e_arg = 16'h0, e_rd = 16'h0;
        for (int c = 0; c < n; c++) begin
            checks++; if (mem_en !== busy) begin errors++; $display("FAIL rand_mem_en @%0d: got %b expected %b", c, mem_en, busy); end
            if (busy) begin
                exp_addr = (is_fetch && second) ? t_addr + 16'd2 : t_addr;
                checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rand_mem_addr @%0d: got %h expected %h", c, mem_addr, exp_addr); end
                checks++; if (mem_we !== (!is_fetch && t_we)) begin errors++; $display("FAIL rand_mem_we @%0d: got %b expected %b", c, mem_we, !is_fetch && t_we); end
                if (!is_fetch && t_we) begin
                    checks++; if (mem_wdata !== t_wdata) begin errors++; $display("FAIL rand_mem_wdata @%0d: got %h expected %h", c, mem_wdata, t_wdata); end
                end
            end
            checks++; if (f_hold !== !fetch_done) begin errors++; $display("FAIL rand_f_hold @%0d: got %b expected %b", c, f_hold, !fetch_done); end
            checks++; if (d_ack !== data_done) begin errors++; $display("FAIL rand_d_ack @%0d: got %b expected %b", c, d_ack, data_done); end
            checks++; if (f_opc !== e_opc || f_arg !== e_arg) begin errors++; $display("FAIL rand_fetch_words @%0d: got %h %h expected %h %h", c, f_opc, f_arg, e_opc, e_arg); end
            checks++; if (d_rdata !== e_rd) begin errors++; $display("FAIL rand_d_rdata @%0d: got %h expected %h", c, d_rdata, e_rd); end

            rst       = ($urandom_range(0, 299) == 0);
            f_req     = ($urandom_range(0, 2) != 0);
            f_addr    = 16'($urandom);
            f_abort   = ($urandom_range(0, 11) == 0);
            d_req     = ($urandom_range(0, 2) == 0);
            d_we      = $urandom_range(0, 1) == 1;
            d_addr    = {12'h7F0, 4'($urandom)};
            d_wdata   = 16'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);

            ready = WAIT_EN ? mem_ready : 1'b1;
            nf = 1'b0;
            nd = 1'b0;
            if (rst) begin
                busy = 1'b0; last_d = 1'b0; t_abort = 1'b0;
                e_opc = 16'h0; e_arg = 16'h0; e_rd = 16'h0;
            end else if (busy) begin
                if (is_fetch && f_abort) t_abort = 1'b1;
                if (ready) begin
                    if (!is_fetch) begin
                        if (t_we) mem[t_addr] = t_wdata;
                        else      e_rd = mem[t_addr];
                        nd = 1'b1;
                        busy = 1'b0;
                    end else if (!second) begin
                        if (t_abort) busy = 1'b0;
                        else begin pend = mem[t_addr]; second = 1'b1; end
                    end else begin
                        if (!t_abort) begin
                            e_opc = pend;
                            e_arg = mem[t_addr + 16'd2];
                            nf = 1'b1;
                        end
                        busy = 1'b0;
                    end
                end
            end else begin
                want_d = d_req && !data_done;
                want_f = f_req && !fetch_done;
                pick_d = (want_d && want_f) ? !last_d : want_d;
                if (want_d || want_f) begin
                    busy = 1'b1; is_fetch = !pick_d; second = 1'b0; t_abort = 1'b0;
                    last_d = pick_d;
                    t_addr = pick_d ? d_addr : f_addr;
                    t_we = d_we; t_wdata = d_wdata;
                end
            end
            fetch_done = nf;
            data_done  = nd;
            tick();
        end
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0; f_abort = 1'b0; mem_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        rst = 1'b1; f_req = 1'b0; f_addr = 16'h0; f_abort = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        mem_ready = 1'b1;
        test_reset();
        test_contention();
        test_fetch();
        test_wrap();
        test_abort();
        test_store_wait();
        test_reset_midbeat();
        test_random(4000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
